// File: rtl/regfile_sequencer.sv
// Command sequencer for a T1..T4 / R1..R4 register file: issues one function per command
// and can read the target back afterwards, comparing it against the value the function should produce.
module regfile_sequencer #(
    parameter int unsigned CHECK_EN = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_reg,
    input  logic [7:0] cmd_data,
    input  logic       cmd_check,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] I,
    output logic [1:0] FunSel,
    output logic [3:0] RSel,
    output logic [3:0] TSel,
    output logic [2:0] O1Sel,
    output logic [2:0] O2Sel,
    input  logic [7:0] O1
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        APPLY = 3'd2,
        POST  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [2:0]  reg_r;
    logic [7:0]  data_r;
    logic        chk_r;
    logic [7:0]  pre_r;
    logic        check_s;

    // Value the target must hold after the function; wraps modulo 256.
    function automatic logic [7:0] expected_value(input logic [1:0] op,
                                                  input logic [7:0] data,
                                                  input logic [7:0] pre);
        logic [7:0] result;
        case (op)
            2'b00:   result = pre - 8'd1;
            2'b01:   result = pre + 8'd1;
            2'b10:   result = data;
            2'b11:   result = 8'h00;
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // {RSel, TSel} with a single bit set for the addressed register (bit3 = x1 ... bit0 = x4).
    function automatic logic [7:0] enables_for(input logic [2:0] rg);
        logic [3:0] one_hot;
        one_hot = 4'b1000 >> rg[1:0];
        return rg[2] ? {one_hot, 4'b0000} : {4'b0000, one_hot};
    endfunction

    assign check_s = (CHECK_EN != 0) && cmd_check;
    assign O2Sel   = 3'b000;

    // Sequencer FSM; every interface output is a register so enables are glitch-free.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= IDLE;
            op_r      <= 2'b00;
            reg_r     <= 3'b000;
            data_r    <= 8'h00;
            chk_r     <= 1'b0;
            pre_r     <= 8'h00;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            I         <= 8'h00;
            FunSel    <= 2'b00;
            RSel      <= 4'b0000;
            TSel      <= 4'b0000;
            O1Sel     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= cmd_op;
                        reg_r     <= cmd_reg;
                        data_r    <= cmd_data;
                        chk_r     <= check_s;
                        cmd_ready <= 1'b0;
                        // Inc/dec need the old value before the expected result is known.
                        if (check_s && !cmd_op[1]) begin
                            state_r <= PRE;
                            O1Sel   <= cmd_reg;
                        end else begin
                            state_r      <= APPLY;
                            FunSel       <= cmd_op;
                            I            <= cmd_data;
                            {RSel, TSel} <= enables_for(cmd_reg);
                        end
                    end
                end
                PRE: begin
                    pre_r        <= O1;
                    O1Sel        <= 3'b000;
                    state_r      <= APPLY;
                    FunSel       <= op_r;
                    I            <= data_r;
                    {RSel, TSel} <= enables_for(reg_r);
                end
                APPLY: begin
                    FunSel <= 2'b00;
                    I      <= 8'h00;
                    RSel   <= 4'b0000;
                    TSel   <= 4'b0000;
                    if (chk_r) begin
                        state_r <= POST;
                        O1Sel   <= reg_r;
                    end else begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b0;
                    end
                end
                POST: begin
                    rsp_data  <= O1;
                    rsp_err   <= (O1 != expected_value(op_r, data_r, pre_r));
                    rsp_valid <= 1'b1;
                    O1Sel     <= 3'b000;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    FunSel    <= 2'b00;
                    I         <= 8'h00;
                    RSel      <= 4'b0000;
                    TSel      <= 4'b0000;
                    O1Sel     <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register-file model on the other side.
module tb_regfile_sequencer;

    logic       Clock;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       cmd_check;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] I;
    logic [1:0] FunSel;
    logic [3:0] RSel;
    logic [3:0] TSel;
    logic [2:0] O1Sel;
    logic [2:0] O2Sel;
    logic [7:0] O1;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file model: index 0..3 = T1..T4, 4..7 = R1..R4.
    logic [7:0] rf [0:7];
    logic       force_o1 = 1'b0;
    logic       pre_en   = 1'b0;
    logic [2:0] pre_idx  = 3'd0;
    logic [7:0] pre_val  = 8'h00;

    int         lat;
    int         en_cycles;
    logic [3:0] en_rsel;
    logic [3:0] en_tsel;
    logic [1:0] en_fun;
    logic [7:0] en_i;
    logic [2:0] first_o1sel;
    logic [7:0] got_data;
    logic       got_err;

    regfile_sequencer #(.CHECK_EN(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_check(cmd_check),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .I(I), .FunSel(FunSel), .RSel(RSel), .TSel(TSel),
        .O1Sel(O1Sel), .O2Sel(O2Sel), .O1(O1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign O1 = force_o1 ? 8'h5A : rf[O1Sel];

    always @(posedge Clock) begin
        if (pre_en) begin
            rf[pre_idx] <= pre_val;
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (((c >= 4) ? RSel[3 - (c % 4)] : TSel[3 - (c % 4)]) == 1'b1) begin
                    case (FunSel)
                        2'b00:   rf[c] <= rf[c] - 8'd1;
                        2'b01:   rf[c] <= rf[c] + 8'd1;
                        2'b10:   rf[c] <= I;
                        default: rf[c] <= 8'h00;
                    endcase
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [7:0] val);
        @(negedge Clock);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge Clock);
        #1 pre_en = 1'b0;
    endtask

    // Issue one command, watch enables each cycle, then hold rsp_ready low for 'hold' cycles.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rg, input logic [7:0] data,
                           input logic chk, input int hold);
        @(negedge Clock);
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_data  = data;
        cmd_check = chk;
        cmd_valid = 1'b1;
        @(posedge Clock);
        #1 cmd_valid = 1'b0;
        lat = 0;
        en_cycles = 0;
        en_rsel = 4'h0; en_tsel = 4'h0; en_fun = 2'b00; en_i = 8'h00;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge Clock);
            if (n == 1) first_o1sel = O1Sel;
            if (RSel != 4'h0 || TSel != 4'h0) begin
                en_cycles++;
                en_rsel = RSel; en_tsel = TSel; en_fun = FunSel; en_i = I;
            end
            if (rsp_valid) lat = n;
        end
        if (lat == 0) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
        end else begin
            got_data = rsp_data;
            got_err  = rsp_err;
            for (int h = 0; h < hold; h++) begin
                if (h == 0) begin
                    cmd_op = 2'b10; cmd_reg = 3'b100; cmd_data = 8'h77; cmd_check = 1'b0;
                    cmd_valid = 1'b1;
                end
                @(negedge Clock);
                check_eq("stall_rsp_valid", rsp_valid, 1'b1);
                check_eq("stall_rsp_data", rsp_data, got_data);
                check_eq("stall_cmd_ready", cmd_ready, 1'b0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge Clock);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_reg = 3'b000;
        cmd_data = 8'h00; cmd_check = 1'b0; rsp_ready = 1'b0;
        #1 Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rsp_data, 8'h00);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        check_eq("rst_sel", {RSel, TSel}, 8'h00);
        check_eq("rst_i_fun", {I, FunSel}, 10'h000);
        check_eq("rst_o_sel", {O1Sel, O2Sel}, 6'o00);
        Reset = 1'b1;

        // Checked load of R2
        preload(3'd5, 8'h00);
        run_cmd(2'b10, 3'b101, 8'h18, 1'b1, 0);
        check_eq("ldR2_lat", lat, 3);
        check_eq("ldR2_en_cycles", en_cycles, 1);
        check_eq("ldR2_sel", {en_rsel, en_tsel}, 8'b0100_0000);
        check_eq("ldR2_fun_i", {en_fun, en_i}, {2'b10, 8'h18});
        check_eq("ldR2_rsp", {got_data, got_err}, {8'h18, 1'b0});
        check_eq("ldR2_rf", rf[5], 8'h18);

        // Checked increment of T4 at FFh wraps to 00h
        preload(3'd3, 8'hFF);
        run_cmd(2'b01, 3'b011, 8'h00, 1'b1, 0);
        check_eq("incT4_lat", lat, 4);
        check_eq("incT4_pre_sel", first_o1sel, 3'b011);
        check_eq("incT4_en_cycles", en_cycles, 1);
        check_eq("incT4_sel", {en_rsel, en_tsel}, 8'b0000_0001);
        check_eq("incT4_fun", en_fun, 2'b01);
        check_eq("incT4_rsp", {got_data, got_err}, {8'h00, 1'b0});

        // Unchecked clear of R4
        preload(3'd7, 8'h3C);
        run_cmd(2'b11, 3'b111, 8'hA5, 1'b0, 0);
        check_eq("clrR4_lat", lat, 2);
        check_eq("clrR4_en_cycles", en_cycles, 1);
        check_eq("clrR4_sel", {en_rsel, en_tsel}, 8'b0001_0000);
        check_eq("clrR4_fun", en_fun, 2'b11);
        check_eq("clrR4_rsp", {got_data, got_err}, {8'h00, 1'b0});
        check_eq("clrR4_rf", rf[7], 8'h00);

        // Checked decrement of T1 at 00h wraps to FFh
        preload(3'd0, 8'h00);
        run_cmd(2'b00, 3'b000, 8'h00, 1'b1, 0);
        check_eq("decT1_lat", lat, 4);
        check_eq("decT1_sel", {en_rsel, en_tsel}, 8'b0000_1000);
        check_eq("decT1_rsp", {got_data, got_err}, {8'hFF, 1'b0});

        // Read-back corrupted by the model
        force_o1 = 1'b1;
        run_cmd(2'b10, 3'b001, 8'h18, 1'b1, 0);
        force_o1 = 1'b0;
        check_eq("force_rsp", {got_data, got_err}, {8'h5A, 1'b1});

        // Response stalled five cycles while another command is offered
        preload(3'd4, 8'h44);
        run_cmd(2'b10, 3'b010, 8'h2C, 1'b1, 5);
        check_eq("stall_rsp", {got_data, got_err}, {8'h2C, 1'b0});
        @(negedge Clock);
        check_eq("stall_ignored_rf", rf[4], 8'h44);
        check_eq("stall_idle_ready", cmd_ready, 1'b1);
        run_cmd(2'b10, 3'b100, 8'h77, 1'b0, 0);
        check_eq("after_stall_lat", lat, 2);
        check_eq("after_stall_rf", rf[4], 8'h77);

        // Reset asserted between edges while APPLY is driving T1
        preload(3'd0, 8'h11);
        @(negedge Clock);
        cmd_op = 2'b10; cmd_reg = 3'b000; cmd_data = 8'h99; cmd_check = 1'b0; cmd_valid = 1'b1;
        @(posedge Clock);
        #1 cmd_valid = 1'b0;
        #2;
        check_eq("rstapply_pre_tsel", TSel, 4'b1000);
        Reset = 1'b0;
        #1;
        check_eq("rstapply_sel", {RSel, TSel}, 8'h00);
        check_eq("rstapply_ready", cmd_ready, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        check_eq("rstapply_rf", rf[0], 8'h11);
        @(negedge Clock);
        check_eq("rstapply_idle_ready", cmd_ready, 1'b1);
        check_eq("rstapply_no_rsp", rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
